// File: rtl/bcd_scan_pkg.sv
// bcd_scan_pkg: shared FSM state type and code constants for the BCD scan controller
package bcd_scan_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [6:0] SEG_INVALID = 7'h7F;
  localparam logic [6:0] SEG_NINE = 7'b0001100;
endpackage

// File: rtl/bcd_digit_lut.sv
// bcd_digit_lut: combinational BCD-to-code map; ports digit[3:0] in, code[6:0] out (0..8 -> n+1, 9 -> SEG_NINE, 10..15 -> SEG_INVALID)
module bcd_digit_lut
  import bcd_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] code
);
  always_comb code = digit < 4'd9 ? {3'b000, digit} + 7'd1 : digit == 4'd9 ? SEG_NINE : SEG_INVALID;
endmodule

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: multiplexed NDIG-digit BCD scan controller with one-entry shadow load (load_valid/load_ready/load_bcd), enable, one-hot dig_sel, seg_code, sticky digit_err/err_clr, frame_done; optional BLANK_LEADING_ZERO_EN blanks leading zero digits
module bcd_scan_ctrl
  import bcd_scan_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DWELL = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_bcd,
  input  logic              enable,
  output logic [NDIG-1:0]   dig_sel,
  output logic [6:0]        seg_code,
  output logic              digit_err,
  input  logic              err_clr,
  output logic              frame_done
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(DWELL);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4*NDIG-1:0] shadow, active;
  logic shadow_full, active_valid;
  logic run, dwell_end, boundary, xfer, bad;
  logic [NDIG-1:0] blank;
  logic [6:0] code;
  assign load_ready = !shadow_full;
  assign run = state == SCAN && enable;
  assign dwell_end = cnt == CW'(DWELL-1);
  assign boundary = run && dwell_end && idx == IW'(NDIG-1);
  assign xfer = shadow_full && (state == IDLE || boundary);
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) bad = bad | (shadow[4*i +: 4] > 4'd9);
  end
`ifdef BLANK_LEADING_ZERO_EN
  always_comb begin
    logic lz;
    lz = 1'b1;
    blank = '0;
    for (int i = NDIG-1; i >= 0; i--) begin
      lz = lz & (active[4*i +: 4] == 4'd0);
      blank[i] = (i > 0) & lz;
    end
  end
`else
  assign blank = '0;
`endif
  bcd_digit_lut u_lut (
    .digit(active[4*idx +: 4]),
    .code (code)
  );
  always_comb begin
    state_n = run || (state == IDLE && enable && (active_valid || xfer)) ? SCAN : IDLE;
    cnt_n = run && !dwell_end ? cnt + CW'(1) : '0;
    idx_n = !run ? '0 : !dwell_end ? idx : idx == IW'(NDIG-1) ? '0 : idx + IW'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow <= '0;
      shadow_full <= 1'b0;
      active <= '0;
      active_valid <= 1'b0;
      digit_err <= 1'b0;
      frame_done <= 1'b0;
      dig_sel <= '0;
      seg_code <= SEG_INVALID;
    end else begin
      if (load_valid && !shadow_full) shadow <= load_bcd;
      shadow_full <= shadow_full ? !xfer : load_valid;
      if (xfer) active <= shadow;
      active_valid <= active_valid | xfer;
      digit_err <= xfer && bad ? 1'b1 : err_clr ? 1'b0 : digit_err;
      frame_done <= boundary;
      dig_sel <= run ? (NDIG'(1) << idx) & ~blank : '0;
      seg_code <= run ? code : SEG_INVALID;
    end
endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb_bcd_scan_ctrl: self-checking bench for bcd_scan_ctrl (NDIG=4, DWELL=4) against a frame-time model
module tb_bcd_scan_ctrl;
  localparam int NDIG = 4, DWELL = 4, FRAME = NDIG*DWELL;
  logic clk = 0, rst_n = 0, load_valid = 0, enable = 0, err_clr = 0;
  logic [15:0] load_bcd = 0;
  logic load_ready, digit_err, frame_done;
  logic [3:0] dig_sel;
  logic [6:0] seg_code;
  int checks = 0, errors = 0;
  bcd_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_bcd(load_bcd), .enable(enable), .dig_sel(dig_sel), .seg_code(seg_code),
    .digit_err(digit_err), .err_clr(err_clr), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  bit m_scan, m_av, m_err;
  int t, m_active;
  int q[$];
  logic [3:0] e_sel;
  logic [6:0] e_seg;
  logic e_fd, e_ready;
  function automatic logic [6:0] code(input int d);
    return d < 9 ? 7'(d+1) : d == 9 ? 7'b0001100 : 7'h7F;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_scan = 0; m_av = 0; m_err = 0; t = 0; m_active = 0; q.delete();
    e_sel = 0; e_seg = 7'h7F; e_fd = 0; e_ready = 1;
  endtask
  task automatic step();
    bit run, bnd, xf, acc, bad;
    int d;
    run = m_scan && enable;
    bnd = run && t == FRAME-1;
    xf = q.size() > 0 && (!m_scan || bnd);
    acc = load_valid && q.size() == 0;
    bad = 0;
    if (xf) for (int i = 0; i < NDIG; i++) if (((q[0] >> (4*i)) & 15) > 9) bad = 1;
    d = t / DWELL;
    e_sel = 0;
    e_seg = 7'h7F;
    if (run) begin
      e_sel = 4'(1 << d);
      e_seg = code((m_active >> (4*d)) & 15);
`ifdef BLANK_LEADING_ZERO_EN
      if (d > 0 && (m_active >> (4*d)) == 0) e_sel = 0;
`endif
    end
    e_fd = bnd;
    m_err = (xf && bad) ? 1 : err_clr ? 0 : m_err;
    if (run) t = (t + 1) % FRAME;
    else begin
      t = 0;
      m_scan = !m_scan && enable && (m_av || xf);
    end
    if (xf) begin m_active = q.pop_front(); m_av = 1; end
    if (acc) q.push_back(int'(load_bcd));
    e_ready = q.size() == 0;
  endtask
  task automatic cycle(input bit lv, input logic [15:0] b, input bit en, input bit clr);
    load_valid = lv; load_bcd = b; enable = en; err_clr = clr;
    step();
    @(posedge clk);
    @(negedge clk);
    chk("dig_sel", dig_sel, e_sel);
    chk("seg_code", seg_code, e_seg);
    chk("frame_done", frame_done, e_fd);
    chk("load_ready", load_ready, e_ready);
    chk("digit_err", digit_err, m_err);
  endtask
  task automatic idle(input int n, input bit clr);
    repeat (n) cycle(0, 16'h0, 1, clr);
  endtask
  initial begin
    logic [15:0] b;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_sel", dig_sel, 4'b0000);
    chk("rst_seg", seg_code, 7'h7F);
    chk("rst_ready", load_ready, 1'b1);
    chk("rst_err", digit_err, 1'b0);
    rst_n = 1;
    cycle(1, 16'h1239, 1, 0);
    chk("lit_ready_after_accept", load_ready, 1'b0);
    idle(1, 0);
    chk("lit_sel_before_first", dig_sel, 4'b0000);
    idle(1, 0);
    chk("lit_d0_sel", dig_sel, 4'b0001);
    chk("lit_d0_seg", seg_code, 7'b0001100);
    idle(4, 0);
    chk("lit_d1_sel", dig_sel, 4'b0010);
    chk("lit_d1_seg", seg_code, 7'b0000100);
    cycle(1, 16'h5678, 1, 0);
    chk("lit_mid_ready", load_ready, 1'b0);
    idle(9, 0);
    chk("lit_d3_sel", dig_sel, 4'b1000);
    chk("lit_d3_seg", seg_code, 7'b0000010);
    chk("lit_ready_hold", load_ready, 1'b0);
    idle(1, 0);
    chk("lit_frame_done", frame_done, 1'b1);
    chk("lit_ready_boundary", load_ready, 1'b1);
    idle(1, 0);
    chk("lit_new_d0_seg", seg_code, 7'b0001001);
    chk("lit_fd_pulse", frame_done, 1'b0);
    cycle(1, 16'h00A5, 1, 0);
    idle(14, 0);
    chk("lit_err_set", digit_err, 1'b1);
    idle(1, 0);
    chk("lit_a5_d0_seg", seg_code, 7'b0000110);
    idle(4, 0);
    chk("lit_a5_d1_sel", dig_sel, 4'b0010);
    chk("lit_a5_d1_seg", seg_code, 7'h7F);
    cycle(1, 16'hB000, 1, 0);
    idle(9, 0);
    idle(1, 1);
    chk("lit_set_wins", digit_err, 1'b1);
    idle(1, 1);
    chk("lit_err_clr", digit_err, 1'b0);
    idle(8, 0);
    chk("lit_d2_sel", dig_sel, 4'b0100);
    chk("lit_d2_seg", seg_code, 7'b0000001);
    cycle(0, 16'h0, 0, 0);
    chk("lit_drop_sel", dig_sel, 4'b0000);
    chk("lit_drop_seg", seg_code, 7'h7F);
    cycle(0, 16'h0, 0, 0);
    idle(1, 0);
    chk("lit_restart_gap", dig_sel, 4'b0000);
    idle(1, 0);
    chk("lit_restart_sel", dig_sel, 4'b0001);
    chk("lit_restart_seg", seg_code, 7'b0000001);
    cycle(1, 16'h0040, 1, 0);
    idle(15, 0);
    chk("lit_z_d0_sel", dig_sel, 4'b0001);
    chk("lit_z_d0_seg", seg_code, 7'b0000001);
    idle(4, 0);
    chk("lit_z_d1_sel", dig_sel, 4'b0010);
    chk("lit_z_d1_seg", seg_code, 7'b0000101);
    idle(4, 0);
`ifdef BLANK_LEADING_ZERO_EN
    chk("lit_z_d2_sel", dig_sel, 4'b0000);
`else
    chk("lit_z_d2_sel", dig_sel, 4'b0100);
`endif
    chk("lit_z_d2_seg", seg_code, 7'b0000001);
    cycle(1, 16'h9999, 1, 0);
    #2 rst_n = 0;
    #1;
    chk("midrst_sel", dig_sel, 4'b0000);
    chk("midrst_seg", seg_code, 7'h7F);
    chk("midrst_ready", load_ready, 1'b1);
    chk("midrst_err", digit_err, 1'b0);
    chk("midrst_fd", frame_done, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    idle(3, 0);
    chk("lit_idle_no_data", dig_sel, 4'b0000);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NDIG; i++) b[4*i +: 4] = 4'($urandom_range(0, ($urandom_range(0, 9) == 0) ? 15 : 9));
      cycle($urandom_range(0, 3) == 0, b, $urandom_range(0, 39) != 0, $urandom_range(0, 19) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit BCD display.
- Accepts a packed NDIG-digit BCD word through a valid/ready handshake and buffers it in a one-entry shadow register.
- Steps one shared BCD-to-code converter across the digits, holding each digit for DWELL cycles and driving a one-hot digit select.
- Sits between the number producer and the display driver pins.

Parameters:
NDIG, 4, number of BCD digits scanned per frame
DWELL, 1000, clock cycles each digit is held (must be ≥2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  producer has a BCD word on load_bcd
load_ready  out  1  shadow register empty; load accepted when valid&ready at a clk edge
load_bcd  in  4*NDIG  packed BCD; nibble 0 = bits[3:0] = least significant digit
enable  in  1  scan enable
dig_sel  out  NDIG  one-hot digit select; bit i drives digit i
seg_code  out  7  converted code for the selected digit
digit_err  out  1  sticky: a nibble >9 was transferred to the active register
err_clr  in  1  clears digit_err
frame_done  out  1  one-cycle pulse when the last digit's dwell ends

Behaviour:
- Reset, asynchronous with rst_n low:
  - dig_sel=0, seg_code=7'h7F, load_ready=1, digit_err=0, frame_done=0.
  - Shadow is emptied and the active register cleared.
  - FSM goes to IDLE; digit index and dwell counter go to 0.
- Code map (shared converter):
  - 0→1, 1→2, 2→3, 3→4, 4→5, 5→6, 6→7, 7→8, 8→9, 9→7'b0001100.
  - 10..15→7'h7F.
- Shadow handshake:
  - load_ready = !shadow_full.
  - An accepting edge captures load_bcd into the shadow and sets shadow_full.
- Transfer from shadow to active, clearing shadow_full, happens:
  - in IDLE, on the edge after shadow_full is seen;
  - in SCAN, only at a frame boundary (last digit, dwell counter = DWELL-1).
  - A load accepted on the boundary edge itself waits for the next boundary.
- Active register state: active_valid is set on the first transfer and stays set until reset.
- FSM states:
  - IDLE: dig_sel=0, seg_code=7'h7F. If enable and (active_valid or a transfer this edge), go to SCAN with index=0 and counter=0.
  - SCAN: counter increments each cycle. At DWELL-1 the counter goes to 0 and the index increments. At index NDIG-1 the index wraps to 0, frame_done pulses and a pending transfer occurs.
  - SCAN with enable low at an edge: go to IDLE immediately; index and counter go to 0.
- Output timing:
  - dig_sel and seg_code are registered from (state, index, active).
  - The new digit appears one edge after the index changes.
  - First digit is visible 2 edges after the accepting edge (accept, then transfer/SCAN, then output).
- digit_err:
  - Set on any transfer containing a nibble >9.
  - Cleared by err_clr.
  - Simultaneous set and err_clr: set wins.
- Enable and frame_done:
  - Enable high with no data ever loaded: remain in IDLE.
  - frame_done is registered, aligned with the edge at which the index wraps to 0.

Optional Feature:
- Macro BLANK_LEADING_ZERO_EN.
- When defined:
  - Any zero digit more significant than the highest nonzero digit has its dig_sel bit forced to 0 during its dwell slot, with slot timing unchanged.
  - Digit 0 is never blanked.
- When undefined: every digit is driven.

Decomposition:
- Shared package bcd_scan_pkg holds:
  - the FSM state typedef (IDLE, SCAN);
  - the invalid code constant 7'h7F;
  - the code-map constant for digit 9 (7'b0001100).
- One sub-module, bcd_digit_lut: purely combinational 4-bit→7-bit code map, instantiated once.

Test Plan:
(All scenarios use NDIG=4, DWELL=4.)
1. Reset check: assert rst_n=0 mid-scan → outputs go immediately to dig_sel=0, seg_code=7'h7F, load_ready=1, digit_err=0. After release with enable=1 and no load, the FSM stays IDLE.
2. Basic scan:
   - Stimulus: load 16'h1239 with enable=1.
   - Response: dig_sel=0001 with seg_code=7'b0001100 for 4 cycles, then 0010/7'b0000100, 0100/7'b0000011, 1000/7'b0000010.
   - frame_done pulses once at the wrap; the pattern then repeats.
3. Mid-frame load:
   - Stimulus: load 16'h5678 while digit 1 is showing.
   - Response: load_ready stays 0 until the boundary. The remainder of the frame still shows 1239. The next frame starts with seg_code=7'b0001001 (digit 8).
4. Invalid digit and error clear:
   - Stimulus: load 16'h00A5.
   - Response: digit_err=1 after the transfer; digit 1 shows 7'h7F. err_clr asserted in the same cycle as a fresh invalid transfer leaves digit_err=1; err_clr alone clears it.
5. Enable drop: deassert enable during digit 2 → next edge gives IDLE with dig_sel=0. Re-enabling restarts at digit 0 with the held value.
6. BLANK_LEADING_ZERO_EN defined:
   - Stimulus: load 16'h0040.
   - Response: digits 3 and 2 slots have dig_sel=0000. Digit 1 shows 0010/7'b0000101. Digit 0 shows 0001/7'b0000001.
